umips_lcd_ctrl: RTL and testbench



---
 rtl/umips_lcd_pkg.sv | 28 ++
 rtl/umips_lcd_ctrl_if.sv | 20 ++
 rtl/umips_lcd_timer.sv | 36 +++
 rtl/umips_lcd_ctrl.sv | 120 ++++++++++++
 tb/tb_umips_lcd_ctrl.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/umips_lcd_pkg.sv
// Shared types, default timing and helpers for the HD44780 write controller.
package umips_lcd_pkg;

    localparam int unsigned LCD_CW = 20;

    // Default cycle counts at 50 MHz
    localparam int unsigned T_POWERON_DEF    = 750000;
    localparam int unsigned T_SETUP_DEF      = 4;
    localparam int unsigned T_PULSE_DEF      = 25;
    localparam int unsigned T_HOLD_DEF       = 4;
    localparam int unsigned T_WAIT_SHORT_DEF = 2000;
    localparam int unsigned T_WAIT_LONG_DEF  = 82000;

    typedef enum logic [2:0] {
        StPwrup = 3'd0,
        StIdle  = 3'd1,
        StSetup = 3'd2,
        StPulse = 3'd3,
        StHold  = 3'd4,
        StWait  = 3'd5
    } lcd_state_e;

    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
    endfunction

endpackage

// File: rtl/umips_lcd_ctrl_if.sv
// Command handshake between the MMIO register bank and the LCD write controller.
interface umips_lcd_ctrl_if;

    logic       cmd_valid;
    logic       cmd_rs;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       busy;

    modport master (
        output cmd_valid, cmd_rs, cmd_data,
        input  cmd_ready, busy
    );

    modport slave (
        input  cmd_valid, cmd_rs, cmd_data,
        output cmd_ready, busy
    );

endinterface

// File: rtl/umips_lcd_timer.sv
// Loadable down-counter shared by all timed controller states; stops at zero.
module umips_lcd_timer
    import umips_lcd_pkg::*;
#(
    parameter int unsigned          Width    = LCD_CW,
    parameter logic [Width-1:0]     ResetVal = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [Width-1:0] value,
    output logic             zero
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= ResetVal;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/umips_lcd_ctrl.sv
// HD44780 write controller: one byte+RS per handshake, hardware-timed EN strobe and exec wait.
module umips_lcd_ctrl
    import umips_lcd_pkg::*;
#(
    parameter int unsigned T_POWERON    = T_POWERON_DEF,
    parameter int unsigned T_SETUP      = T_SETUP_DEF,
    parameter int unsigned T_PULSE      = T_PULSE_DEF,
    parameter int unsigned T_HOLD       = T_HOLD_DEF,
    parameter int unsigned T_WAIT_SHORT = T_WAIT_SHORT_DEF,
    parameter int unsigned T_WAIT_LONG  = T_WAIT_LONG_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    umips_lcd_ctrl_if.slave        cmd,
    output logic                   LCD_EN,
    output logic                   LCD_RS,
    output logic                   LCD_RW,
    output logic [7:0]             LCD_DATA
);

    // Counter reload values: a state lasts T_X cycles when loaded with T_X-1
    localparam logic [LCD_CW-1:0] LdPoweron = LCD_CW'(T_POWERON - 1);
    localparam logic [LCD_CW-1:0] LdSetup   = LCD_CW'(T_SETUP - 1);
    localparam logic [LCD_CW-1:0] LdPulse   = LCD_CW'(T_PULSE - 1);
    localparam logic [LCD_CW-1:0] LdHold    = LCD_CW'(T_HOLD - 1);
    localparam logic [LCD_CW-1:0] LdShort   = LCD_CW'(T_WAIT_SHORT - 1);
    localparam logic [LCD_CW-1:0] LdLong    = LCD_CW'(T_WAIT_LONG - 1);

    lcd_state_e        state_q, state_d;
    logic              en_q, en_d;
    logic              rs_q, rs_d;
    logic [7:0]        data_q, data_d;
    logic              long_q, long_d;
    logic              load;
    logic [LCD_CW-1:0] load_val;
    logic              zero;

    umips_lcd_timer #(
        .Width    (LCD_CW),
        .ResetVal (LdPoweron)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .value (load_val),
        .zero  (zero)
    );

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        rs_d     = rs_q;
        data_d   = data_q;
        long_d   = long_q;
        load     = 1'b0;
        load_val = LdSetup;
        unique case (state_q)
            StPwrup: if (zero) state_d = StIdle;
            StIdle: begin
                if (cmd.cmd_valid) begin
                    state_d  = StSetup;
                    rs_d     = cmd.cmd_rs;
                    data_d   = cmd.cmd_data;
                    long_d   = is_long_cmd(cmd.cmd_rs, cmd.cmd_data);
                    load     = 1'b1;
                    load_val = LdSetup;
                end
            end
            StSetup: begin
                if (zero) begin
                    state_d  = StPulse;
                    en_d     = 1'b1;
                    load     = 1'b1;
                    load_val = LdPulse;
                end
            end
            StPulse: begin
                if (zero) begin
                    state_d  = StHold;
                    en_d     = 1'b0;
                    load     = 1'b1;
                    load_val = LdHold;
                end
            end
            StHold: begin
                if (zero) begin
                    state_d  = StWait;
                    load     = 1'b1;
                    load_val = long_q ? LdLong : LdShort;
                end
            end
            StWait: if (zero) state_d = StIdle;
            default: state_d = StPwrup;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StPwrup;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            long_q  <= long_d;
        end
    end

    assign cmd.cmd_ready = (state_q == StIdle);
    assign cmd.busy      = (state_q != StIdle);
    assign LCD_EN        = en_q;
    assign LCD_RS        = rs_q;
    assign LCD_RW        = 1'b0;
    assign LCD_DATA      = data_q;

endmodule

// File: tb/tb_umips_lcd_ctrl.sv
// Directed bench for umips_lcd_ctrl using small timing parameters.
module tb_umips_lcd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;
    int         total = 0;
    int         bad   = 0;

    umips_lcd_ctrl_if cmd_if ();

    umips_lcd_ctrl #(
        .T_POWERON    (10),
        .T_SETUP      (2),
        .T_PULSE      (3),
        .T_HOLD       (2),
        .T_WAIT_SHORT (5),
        .T_WAIT_LONG  (20)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd      (cmd_if),
        .LCD_EN   (lcd_en),
        .LCD_RS   (lcd_rs),
        .LCD_RW   (lcd_rw),
        .LCD_DATA (lcd_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pins(input string tag, input logic en, input logic rdy);
        chk({tag, "_en"}, 32'(lcd_en), 32'(en));
        chk({tag, "_ready"}, 32'(cmd_if.cmd_ready), 32'(rdy));
        chk({tag, "_busy"}, 32'(cmd_if.busy), 32'(!rdy));
        chk({tag, "_rw"}, 32'(lcd_rw), 32'd0);
    endtask

    // Called just after reset release; 10 busy cycles then ready
    task automatic powerup(input string tag);
        chk_pins(tag, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk_pins(tag, 1'b0, i == 10);
            chk({tag, "_rs"}, 32'(lcd_rs), 32'd0);
            chk({tag, "_data"}, 32'(lcd_data), 32'h00);
        end
    endtask

    // Called one step after an edge where ready=1; returns in the same phase with ready=1
    task automatic send(input string tag, input logic rs, input logic [7:0] data,
                        input int ready_at);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_rs    = rs;
        cmd_if.cmd_data  = data;
        tick();
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_rs    = ~rs;
        cmd_if.cmd_data  = ~data;
        chk({tag, "_rs"}, 32'(lcd_rs), 32'(rs));
        chk({tag, "_data"}, 32'(lcd_data), 32'(data));
        chk_pins(tag, 1'b0, 1'b0);
        for (int j = 1; j <= ready_at; j++) begin
            tick();
            chk_pins(tag, (j >= 2) && (j < 5), j == ready_at);
        end
        chk({tag, "_data_kept"}, 32'(lcd_data), 32'(data));
    endtask

    initial begin
        rst_n            = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_rs    = 1'b0;
        cmd_if.cmd_data  = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        chk_pins("rst", 1'b0, 1'b0);
        chk("rst_rs", 32'(lcd_rs), 32'd0);
        chk("rst_data", 32'(lcd_data), 32'h00);
        tick();
        tick();
        chk_pins("rst_hold", 1'b0, 1'b0);
        rst_n = 1'b1;
        powerup("pwr");

        send("d41", 1'b1, 8'h41, 12);
        send("i01", 1'b0, 8'h01, 27);
        send("i38", 1'b0, 8'h38, 12);
        send("i03", 1'b0, 8'h03, 27);
        send("i02", 1'b0, 8'h02, 27);
        send("i00", 1'b0, 8'h00, 12);
        send("i04", 1'b0, 8'h04, 12);
        send("d01", 1'b1, 8'h01, 12);

        // cmd_valid held with new data while busy: accepted only on the first ready cycle
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_rs    = 1'b0;
        cmd_if.cmd_data  = 8'h38;
        tick();
        cmd_if.cmd_rs   = 1'b1;
        cmd_if.cmd_data = 8'h55;
        for (int j = 1; j <= 12; j++) begin
            tick();
            chk("hold_data", 32'(lcd_data), 32'h38);
            chk("hold_rs", 32'(lcd_rs), 32'd0);
            chk_pins("hold", (j >= 2) && (j < 5), j == 12);
        end
        tick();
        cmd_if.cmd_valid = 1'b0;
        chk("b2b_data", 32'(lcd_data), 32'h55);
        chk("b2b_rs", 32'(lcd_rs), 32'd1);
        chk_pins("b2b", 1'b0, 1'b0);
        for (int j = 1; j <= 12; j++) begin
            tick();
            chk_pins("b2b", (j >= 2) && (j < 5), j == 12);
        end

        // Reset in the middle of the EN pulse
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_rs    = 1'b1;
        cmd_if.cmd_data  = 8'h5a;
        tick();
        cmd_if.cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_en_high", 32'(lcd_en), 32'd1);
        chk("mid_data", 32'(lcd_data), 32'h5a);
        #1 rst_n = 1'b0;
        #1;
        chk_pins("async", 1'b0, 1'b0);
        chk("async_rs", 32'(lcd_rs), 32'd0);
        chk("async_data", 32'(lcd_data), 32'h00);
        tick();
        tick();
        rst_n = 1'b1;
        powerup("pwr2");
        send("post", 1'b1, 8'h30, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
